dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised successor to the 32-word register-file data memory.
- Byte-addressed, word-organised RV32 data memory with byte/halfword/word load-store and sign/zero extension.
- Valid/ready request channel, registered response channel with back-pressure, error flag for misaligned, out-of-range or illegal-size accesses.
- Sits between the EX/MEM stage and storage; serves one request per cycle at full throughput.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 2.
- ADDR_W, 32, byte-address width; must be at least log2(DEPTH)+2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when valid and ready are both high at a rising edge.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  3  RV32 funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  consumer accepts the response.
- resp_rdata_o  out  32  load result, extended; 0 for stores and errors.
- resp_err_o  out  1  access rejected.

Behaviour:
- Reset (rst_i high at a rising edge): all DEPTH words become 0. resp_valid_o, resp_rdata_o and resp_err_o become 0. Any pending response is dropped. Reset has priority over every other event.
- Response FSM:
  - Two states: EMPTY and FULL.
  - req_ready_o = (state==EMPTY) or resp_ready_i. This is combinational and gives full throughput.
  - A handshake moves the FSM to FULL and loads the response register.
  - FULL with resp_ready_i high and no new handshake moves to EMPTY.
  - FULL with resp_ready_i low holds all resp_* outputs stable.
- Latency: exactly one cycle. A request accepted at edge N produces resp_valid_o=1 after edge N.
- Word index is addr[log2(DEPTH)+1:2]. Byte lane is addr[1:0].
- Error conditions (resp_err_o=1, no storage change, rdata 0):
  - size is 011, 110 or 111; or a store with size 1xx;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - any address bit at or above log2(DEPTH)+2 is nonzero (out of range).
- Store: byte enables are derived from size and lane; wdata is replicated across lanes. Only the enabled bytes are written, at the accepting edge.
- Load: the selected lane(s) are read at the accepting edge.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW returns the word unchanged.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data. There is no forwarding hazard because the write completes at the accepting edge.
- Single port: one access per cycle, so no same-cycle read/write conflict exists.
- Invalid request fields are ignored when req_valid_i is low; storage never changes without a handshake.

Decomposition:
- Package dmem_pkg:
  - size enum size_e (SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101);
  - localparam helper for index width;
  - struct dmem_req_t {we, size, addr, wdata}.
- Sub-module dmem_lane_align (combinational):
  - inputs: size, addr[1:0], wdata, raw word;
  - outputs: byte enables, lane-replicated wdata, extended rdata, misalign/illegal flag.
- The top level holds the storage array, range check and response FSM.

Test Plan:
- Reset, then LW at 0x0 -> resp_valid_o=1 one cycle later, rdata=0x00000000, err=0.
- SW 0xDEADBEEF @0x10; then LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
- SB 0x5A @0x11 over 0xDEADBEEF; then LW @0x10 -> 0xDEAD5AEF (other bytes untouched).
- LH @0x01, SW @0x02, size 011, LW at byte address DEPTH*4 -> each returns err=1, rdata=0; a subsequent LW confirms memory is unchanged.
- Back-pressure: hold resp_ready_i=0 for 3 cycles after an LW -> req_ready_o=0 and resp_* stable. Release, then stream 4 back-to-back loads -> one response per cycle, in order.
- Pulse rst_i while in FULL with resp_ready_i=0 -> resp_valid_o=0 the next cycle and all previously stored words read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the RV32 data memory LSU.
// Access size codes, request bundle and index-width helper.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  localparam int REQ_AW = 32;

  typedef struct packed {
    logic              we;
    logic [2:0]        size;
    logic [REQ_AW-1:0] addr;
    logic [31:0]       wdata;
  } dmem_req_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for RV32 loads/stores.
// In: we, size, lane, wdata, raw word. Out: byte enables, lane wdata, extended rdata, err.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    rb      = rword_i[8*lane_i +: 8];
    rh      = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    err_o   = 1'b0;
    unique case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{rb[7]}}, rb};
      end
      SZ_BU: begin
        err_o   = we_i;
        be_o    = 4'b0001 << lane_i;
        rdata_o = {24'h0, rb};
      end
      SZ_H: begin
        err_o   = lane_i[0];
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{rh[15]}}, rh};
      end
      SZ_HU: begin
        err_o   = we_i | lane_i[0];
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        rdata_o = {16'h0, rh};
      end
      SZ_W: begin
        err_o   = lane_i != 2'b00;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: DEPTH-word byte-addressed RV32 data memory, 1-cycle registered response.
// Ports: clk_i, rst_i, req_* (valid/ready request), resp_* (valid/ready response, rdata, err).
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_size_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o
);

  localparam int IW = idx_w(DEPTH);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  dmem_req_t   req;
  logic [IW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane, rext, rword;
  logic        lerr, oor, err, hs;
  logic        unused_addr;

  assign req = '{
    we:    req_we_i,
    size:  req_size_i,
    addr:  REQ_AW'(req_addr_i),
    wdata: req_wdata_i
  };

  assign idx   = req.addr[IW+1:2];
  assign rword = mem_q[idx];
  // Any set bit above the array span is out of range.
  assign oor   = |(req_addr_i >> (IW + 2));
  assign err   = lerr | oor;
  assign unused_addr = ^req.addr[REQ_AW-1:IW+2];

  dmem_lane_align u_align (
    .we_i    (req.we),
    .size_i  (req.size),
    .lane_i  (req.addr[1:0]),
    .wdata_i (req.wdata),
    .rword_i (rword),
    .be_o    (be),
    .wdata_o (wlane),
    .rdata_o (rext),
    .err_o   (lerr)
  );

  assign req_ready_o  = (state_q == EMPTY) | resp_ready_i;
  assign hs           = req_valid_i & req_ready_o;
  assign resp_valid_o = state_q == FULL;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (hs) begin
      state_d = FULL;
      rdata_d = (err | req.we) ? 32'h0 : rext;
      err_d   = err;
    end else if (resp_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (hs && req.we && !err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed + random bench for dmem_lsu.
// Byte-array reference model with a response queue, checked every cycle.
module tb_dmem_lsu;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_size_i = 3'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_size_i   (req_size_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [7:0] mem_m [DEPTH*4];
  rsp_t       q [$];

  function automatic rsp_t model(input logic we, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
    rsp_t r;
    int   n;
    r.rdata = 32'h0;
    r.err   = 1'b0;
    n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) r.err = 1'b1;
    if (we && sz[2]) r.err = 1'b1;
    if (a % n != 0) r.err = 1'b1;
    if (a >= 32'(DEPTH * 4)) r.err = 1'b1;
    if (r.err) return r;
    if (we) begin
      for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) r.rdata[8*i +: 8] = mem_m[a + i];
      if (!sz[2] && n < 4 && r.rdata[8*n-1])
        for (int j = n; j < 4; j++) r.rdata[8*j +: 8] = 8'hFF;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    rsp_t r;
    logic rdy;
    if (rst_i) begin
      q.delete();
      for (int i = 0; i < DEPTH * 4; i++) mem_m[i] = 8'h0;
    end else begin
      rdy = (q.size() == 0) || resp_ready_i;
      chk("m_resp_valid", 32'(resp_valid_o), 32'(q.size() != 0));
      chk("m_req_ready", 32'(req_ready_o), 32'(rdy));
      if (q.size() != 0) begin
        chk("m_rdata", resp_rdata_o, q[0].rdata);
        chk("m_err", 32'(resp_err_o), 32'(q[0].err));
        if (resp_ready_i) void'(q.pop_front());
      end
      if (req_valid_i && rdy) begin
        r = model(req_we_i, req_size_i, req_addr_i, req_wdata_i);
        q.push_back(r);
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic rr);
    int  n;
    logic acc;
    @(posedge clk);
    #1;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_size_i   = sz;
    req_addr_i   = a;
    req_wdata_i  = wd;
    resp_ready_i = rr;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [31:0] rd,
                     input logic er);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(resp_valid_o), 32'd1);
    chk({nm, "_rdata"}, resp_rdata_o, rd);
    chk({nm, "_err"}, 32'(resp_err_o), 32'(er));
  endtask

  logic [31:0] saddr [4];
  logic [2:0]  ssize [4];

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_err", 32'(resp_err_o), 32'd0);

    send(1'b0, 3'b010, 32'h00, 32'h0, 1'b1);
    lit("lw0", 32'h0, 1'b0);
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
    lit("sw10", 32'h0, 1'b0);
    send(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
    lit("lb13", 32'hFFFFFFDE, 1'b0);
    send(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    lit("lbu13", 32'h000000DE, 1'b0);
    send(1'b0, 3'b001, 32'h10, 32'h0, 1'b1);
    lit("lh10", 32'hFFFFBEEF, 1'b0);
    send(1'b0, 3'b101, 32'h12, 32'h0, 1'b1);
    lit("lhu12", 32'h0000DEAD, 1'b0);
    send(1'b1, 3'b000, 32'h11, 32'hFFFFFF5A, 1'b1);
    lit("sb11", 32'h0, 1'b0);
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    lit("lw10", 32'hDEAD5AEF, 1'b0);

    send(1'b0, 3'b001, 32'h01, 32'h0, 1'b1);
    lit("lh_mis", 32'h0, 1'b1);
    send(1'b1, 3'b010, 32'h02, 32'h11111111, 1'b1);
    lit("sw_mis", 32'h0, 1'b1);
    send(1'b1, 3'b011, 32'h10, 32'h22222222, 1'b1);
    lit("sz3", 32'h0, 1'b1);
    send(1'b1, 3'b100, 32'h10, 32'h33333333, 1'b1);
    lit("sbu", 32'h0, 1'b1);
    send(1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 1'b1);
    lit("lw_oor", 32'h0, 1'b1);
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    lit("lw10_chk", 32'hDEAD5AEF, 1'b0);
    send(1'b0, 3'b010, 32'h00, 32'h0, 1'b1);
    lit("lw0_chk", 32'h0, 1'b0);
    send(1'b1, 3'b010, 32'h14, 32'h13579BDF, 1'b1);
    lit("sw14", 32'h0, 1'b0);

    // Back-pressure: response held while a new load waits.
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_size_i  = 3'b010;
    req_addr_i  = 32'h14;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready_o), 32'd0);
      chk("bp_valid", 32'(resp_valid_o), 32'd1);
      chk("bp_rdata", resp_rdata_o, 32'hDEAD5AEF);
      chk("bp_err", 32'(resp_err_o), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready_i = 1'b1;
    saddr = '{32'h14, 32'h10, 32'h13, 32'h16};
    ssize = '{3'b010, 3'b001, 3'b000, 3'b101};
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1;
      req_addr_i  = saddr[i];
      req_size_i  = ssize[i];
      @(negedge clk);
      chk("st_valid", 32'(resp_valid_o), 32'd1);
      chk("st_ready", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("st_last", resp_rdata_o, 32'h00001357);
    chk("st_last_v", 32'(resp_valid_o), 32'd1);

    // Reset while FULL and stalled.
    send(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
    lit("pre_rst", 32'h13579BDF, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("prst_valid", 32'(resp_valid_o), 32'd0);
    chk("prst_rdata", resp_rdata_o, 32'h0);
    chk("prst_err", 32'(resp_err_o), 32'd0);
    chk("prst_ready", 32'(req_ready_o), 32'd1);
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    lit("prst_lw10", 32'h0, 1'b0);
    send(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
    lit("prst_lw14", 32'h0, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [2:0] sz;
      @(posedge clk);
      #1;
      case ($urandom_range(0, 9))
        0:       sz = 3'($urandom_range(0, 7));
        1, 2:    sz = 3'b000;
        3, 4:    sz = 3'b001;
        5, 6:    sz = 3'b010;
        7:       sz = 3'b100;
        default: sz = 3'b101;
      endcase
      req_valid_i  = $urandom_range(0, 3) != 0;
      req_we_i     = $urandom_range(0, 2) == 0;
      req_size_i   = sz;
      req_wdata_i  = $urandom;
      resp_ready_i = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0)
        req_addr_i = $urandom | 32'(DEPTH * 4);
      else if ($urandom_range(0, 3) == 0)
        req_addr_i = 32'($urandom_range(0, DEPTH * 4 - 1));
      else
        req_addr_i = 32'($urandom_range(0, DEPTH - 1) * 4);
    end
    @(posedge clk);
    #1;
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
